sevseg_capture: RTL

- Receive-side monitor for the multiplexed, active-low seven-segment display interface: anode strobes plus segment cathodes.
- Samples the scanned display lines, waits for each digit to settle, and decodes its segment pattern back to a 4-bit hex value per digit.
- Used for on-board self-check and loopback testing of the display path, next to the hex-to-segment encoder and the display scanner.

---
 rtl/sevseg_capture.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/sevseg_capture.sv
// Receive-side monitor for a multiplexed active-low seven-segment display: synchronizes the
// scanned lines, waits for a settled digit and decodes it. SEVSEG_CAPTURE_ERRCNT_EN adds err_count.
module sevseg_capture #(
    parameter int unsigned SETTLE_CYCLES = 8,
    parameter int unsigned NUM_DIGITS    = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_DIGITS-1:0]   an,
    input  logic [6:0]              ca,
`ifdef SEVSEG_CAPTURE_ERRCNT_EN
    input  logic                    err_clr,
    output logic [7:0]              err_count,
`endif
    output logic [4*NUM_DIGITS-1:0] digits,
    output logic [NUM_DIGITS-1:0]   digit_valid,
    output logic                    update,
    output logic [2:0]              update_idx,
    output logic                    pat_err
);

    localparam logic [7:0] SettleCnt = 8'(SETTLE_CYCLES);
    localparam logic [6:0] Blank     = 7'h7f;

    typedef enum logic [1:0] {StIdle, StSettle, StCaptured} state_e;

    logic [NUM_DIGITS-1:0]   an_meta_q, an_sync_q, an_prev_q;
    logic [6:0]              ca_meta_q, ca_sync_q, ca_prev_q;
    logic [7:0]              cnt_q, cnt_d;
    state_e                  state_q, state_d;
    logic                    changed, one_low, capture;
    logic [2:0]              low_idx;
    logic [4:0]              dec;

    logic [4*NUM_DIGITS-1:0] digits_q, digits_d;
    logic [NUM_DIGITS-1:0]   valid_q, valid_d;
    logic                    update_q, update_d;
    logic [2:0]              idx_q, idx_d;
    logic                    pat_err_q, pat_err_d;

    // Returns {legal, nibble}; anything outside the 16 hex glyphs is not legal.
    function automatic logic [4:0] decode(input logic [6:0] seg);
        logic [4:0] r;
        case (seg)
            7'b0000001: r = {1'b1, 4'h0};
            7'b1001111: r = {1'b1, 4'h1};
            7'b0010010: r = {1'b1, 4'h2};
            7'b0000110: r = {1'b1, 4'h3};
            7'b1001100: r = {1'b1, 4'h4};
            7'b0100100: r = {1'b1, 4'h5};
            7'b0100000: r = {1'b1, 4'h6};
            7'b0001111: r = {1'b1, 4'h7};
            7'b0000000: r = {1'b1, 4'h8};
            7'b0000100: r = {1'b1, 4'h9};
            7'b0001000: r = {1'b1, 4'hA};
            7'b1100000: r = {1'b1, 4'hB};
            7'b0110001: r = {1'b1, 4'hC};
            7'b1000010: r = {1'b1, 4'hD};
            7'b0110000: r = {1'b1, 4'hE};
            7'b0111000: r = {1'b1, 4'hF};
            default:    r = 5'b0;
        endcase
        return r;
    endfunction

    // Inputs are asynchronous: two flops of synchronization, then one of history for change detect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an_meta_q <= '1;
            an_sync_q <= '1;
            an_prev_q <= '1;
            ca_meta_q <= '1;
            ca_sync_q <= '1;
            ca_prev_q <= '1;
        end else begin
            an_meta_q <= an;
            an_sync_q <= an_meta_q;
            an_prev_q <= an_sync_q;
            ca_meta_q <= ca;
            ca_sync_q <= ca_meta_q;
            ca_prev_q <= ca_sync_q;
        end
    end

    always_comb begin
        changed = ({an_sync_q, ca_sync_q} != {an_prev_q, ca_prev_q});
        one_low = ($countones(~an_sync_q) == 1);
        low_idx = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (!an_sync_q[i]) low_idx = 3'(i);
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        if (!one_low) begin
            state_d = StIdle;
            cnt_d   = '0;
        end else if (changed) begin
            state_d = StSettle;
            cnt_d   = '0;
        end else begin
            if (cnt_q < SettleCnt) cnt_d = cnt_q + 8'd1;
            if (state_q == StCaptured) begin
                state_d = StCaptured;
            end else if (cnt_q == SettleCnt) begin
                state_d = StCaptured;
                capture = 1'b1;
            end else begin
                state_d = StSettle;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        digits_d  = digits_q;
        valid_d   = valid_q;
        update_d  = 1'b0;
        idx_d     = idx_q;
        pat_err_d = 1'b0;
        dec       = decode(ca_prev_q);
        if (capture) begin
            if (dec[4]) begin
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    if (low_idx == 3'(i)) begin
                        digits_d[4*i +: 4] = dec[3:0];
                        valid_d[i]         = 1'b1;
                    end
                end
                update_d = 1'b1;
                idx_d    = low_idx;
            end else if (ca_prev_q == Blank) begin
                // A dark digit invalidates the slot but keeps its last nibble.
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    if (low_idx == 3'(i)) valid_d[i] = 1'b0;
                end
                update_d = 1'b1;
                idx_d    = low_idx;
            end else begin
                pat_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digits_q  <= '0;
            valid_q   <= '0;
            update_q  <= 1'b0;
            idx_q     <= '0;
            pat_err_q <= 1'b0;
        end else begin
            digits_q  <= digits_d;
            valid_q   <= valid_d;
            update_q  <= update_d;
            idx_q     <= idx_d;
            pat_err_q <= pat_err_d;
        end
    end

    assign digits      = digits_q;
    assign digit_valid = valid_q;
    assign update      = update_q;
    assign update_idx  = idx_q;
    assign pat_err     = pat_err_q;

`ifdef SEVSEG_CAPTURE_ERRCNT_EN
    logic [7:0] err_count_q;

    // Counts in step with the pat_err pulse; a clear wins over a same-cycle increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count_q <= '0;
        end else if (err_clr) begin
            err_count_q <= '0;
        end else if (pat_err_d && (err_count_q != 8'hff)) begin
            err_count_q <= err_count_q + 8'd1;
        end
    end

    assign err_count = err_count_q;
`endif

endmodule
